// File: rtl/alu_result_collector_if.sv
// Interface for alu_result_collector.
// Carries the issue tag, the four registered ALU unit results/flags, and the
// result FIFO handshake/status.
//   slave  : the collector (receives issue/ALU/res_ready, drives result side)
//   master : the environment driving issues and ALU outputs, consuming results
interface alu_result_collector_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               issue_valid;
  logic [3:0]         issue_fun;
  logic signed [15:0] Arith_Out;
  logic signed [15:0] Logic_Out;
  logic signed [15:0] CMP_Out;
  logic signed [15:0] Shift_Out;
  logic               Arith_Flag;
  logic               Logic_Flag;
  logic               CMP_Flag;
  logic               Shift_Flag;
  logic               res_valid;
  logic               res_ready;
  logic signed [15:0] res_data;
  logic [3:0]         res_fun;
  logic               res_err;
  logic [CW-1:0]      fifo_count;
  logic               overflow;
  logic [3:0]         drop_count;

  modport slave (
    input  issue_valid, issue_fun,
    input  Arith_Out, Logic_Out, CMP_Out, Shift_Out,
    input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    input  res_ready,
    output res_valid, res_data, res_fun, res_err,
    output fifo_count, overflow, drop_count
  );

  modport master (
    output issue_valid, issue_fun,
    output Arith_Out, Logic_Out, CMP_Out, Shift_Out,
    output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    output res_ready,
    input  res_valid, res_data, res_fun, res_err,
    input  fifo_count, overflow, drop_count
  );
endinterface

// File: rtl/alu_result_collector.sv
// ALU result collector.
// Follows each issued op through a LAT-deep tag pipeline so the tag leaves the
// pipeline in the same cycle the registered ALU outputs for that op are valid.
// On exit the selected unit's result, the op code and a flag-consistency error
// bit are pushed into a DEPTH-entry FIFO read through a valid/ready port.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_result_collector_if.slave (issue, ALU results/flags, result FIFO)
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input logic                 clk,
  input logic                 rst,
  alu_result_collector_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  fun;
    logic        err;
  } entry_t;

  logic [LAT-1:0]      tag_v_q, tag_v_d;
  logic [LAT-1:0][3:0] tag_fun_q, tag_fun_d;
  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [3:0]          drop_q, drop_d;

  logic        exit_v;
  logic [3:0]  exit_fun;
  logic [3:0]  flags;
  logic [15:0] sel_result;
  logic        full, pop, wr, drop;
  entry_t      new_entry;
  entry_t      head;

  always_comb begin
    tag_v_d      = tag_v_q;
    tag_fun_d    = tag_fun_q;
    tag_v_d[0]   = bus.issue_valid;
    tag_fun_d[0] = bus.issue_fun;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_fun_d[i] = tag_fun_q[i-1];
    end
  end

  assign exit_v   = tag_v_q[LAT-1];
  assign exit_fun = tag_fun_q[LAT-1];
  assign flags    = {bus.Shift_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag};

  always_comb begin
    sel_result = 16'd0;
    case (exit_fun[3:2])
      2'b00:   sel_result = bus.Arith_Out;
      2'b01:   sel_result = bus.Logic_Out;
      2'b10:   sel_result = bus.CMP_Out;
      default: sel_result = bus.Shift_Out;
    endcase
  end

  // Exactly the selected unit's flag must be high; anything else is an error.
  always_comb begin
    new_entry.data = sel_result;
    new_entry.fun  = exit_fun;
    new_entry.err  = (flags != (4'b0001 << exit_fun[3:2]));
  end

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) && bus.res_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr   = exit_v && (!full || pop);
  assign drop = exit_v && full && !pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (wr) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop && (drop_q != 4'd15)) drop_d = drop_q + 4'd1;
    count_d = count_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q    <= '0;
      tag_fun_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 4'd0;
    end else begin
      tag_v_q    <= tag_v_d;
      tag_fun_q  <= tag_fun_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  assign head           = mem_q[rd_ptr_q];
  assign bus.res_valid  = (count_q != '0);
  assign bus.res_data   = bus.res_valid ? head.data : 16'd0;
  assign bus.res_fun    = bus.res_valid ? head.fun  : 4'd0;
  assign bus.res_err    = bus.res_valid ? head.err  : 1'b0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  fun;
    logic        err;
  } ent_t;

  typedef struct {
    bit         v;
    logic [3:0] fun;
  } tag_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ent_t q[$];
  tag_t pipe[$];
  bit   m_ovf;
  int   m_drops;

  alu_result_collector_if #(.DEPTH(DEPTH)) bus ();

  alu_result_collector #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    tag_t t;
    q.delete();
    pipe.delete();
    t.v   = 1'b0;
    t.fun = 4'd0;
    for (int i = 0; i < LAT; i++) pipe.push_back(t);
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_all();
    chk("res_valid", 16'(bus.res_valid), 16'(q.size() != 0));
    chk("fifo_count", 16'(bus.fifo_count), 16'(q.size()));
    if (q.size() != 0) begin
      chk("res_data", bus.res_data, q[0].data);
      chk("res_fun", 16'(bus.res_fun), 16'(q[0].fun));
      chk("res_err", 16'(bus.res_err), 16'(q[0].err));
    end
    chk("overflow", 16'(bus.overflow), 16'(m_ovf));
    chk("drop_count", 16'(bus.drop_count), 16'(m_drops));
  endtask

  // Sets issue/ready and drives ALU outputs for the tag that exits at the
  // next edge: correct one-hot flags when an op exits, random junk otherwise.
  task automatic drive(input bit iv, input logic [3:0] fun, input bit rdy, input bit inj);
    logic [3:0] f;
    bus.issue_valid = iv;
    bus.issue_fun   = fun;
    bus.res_ready   = rdy;
    bus.Arith_Out   = 16'($urandom);
    bus.Logic_Out   = 16'($urandom);
    bus.CMP_Out     = 16'($urandom);
    bus.Shift_Out   = 16'($urandom);
    if (pipe[0].v) f = 4'b0001 << pipe[0].fun[3:2];
    else           f = 4'($urandom);
    if (inj) f[$urandom_range(3)] = ~f[$urandom_range(3)];
    {bus.Shift_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag} = f;
  endtask

  // Reference model step: evaluated from the inputs present before the edge.
  task automatic tick();
    tag_t       ex, t;
    ent_t       e;
    logic [3:0] f;
    int         sel;
    bit         pop;
    ex    = pipe.pop_front();
    t.v   = bus.issue_valid;
    t.fun = bus.issue_fun;
    pipe.push_back(t);
    pop = bus.res_ready && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (ex.v) begin
      sel   = int'(ex.fun[3:2]);
      f     = {bus.Shift_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag};
      e.err = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i == sel && !f[i]) e.err = 1'b1;
        if (i != sel &&  f[i]) e.err = 1'b1;
      end
      case (sel)
        0:       e.data = bus.Arith_Out;
        1:       e.data = bus.Logic_Out;
        2:       e.data = bus.CMP_Out;
        default: e.data = bus.Shift_Out;
      endcase
      e.fun = ex.fun;
      if (q.size() < DEPTH) q.push_back(e);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 15) m_drops++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic async_reset();
    bus.issue_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 16'(bus.res_valid), 16'd0);
    chk("rst_count", 16'(bus.fifo_count), 16'd0);
    chk("rst_data", bus.res_data, 16'd0);
    chk("rst_ovf", 16'(bus.overflow), 16'd0);
    chk("rst_drops", 16'(bus.drop_count), 16'd0);
    model_clear();
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] funs [5];
    funs = '{4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b1100};
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_fun   = 4'd0;
    bus.res_ready   = 1'b0;
    bus.Arith_Out = 16'd0; bus.Logic_Out = 16'd0; bus.CMP_Out = 16'd0; bus.Shift_Out = 16'd0;
    bus.Arith_Flag = 1'b0; bus.Logic_Flag = 1'b0; bus.CMP_Flag = 1'b0; bus.Shift_Flag = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_valid", 16'(bus.res_valid), 16'd0);
    chk("reset_count", 16'(bus.fifo_count), 16'd0);
    chk("reset_data", bus.res_data, 16'd0);
    chk("reset_fun", 16'(bus.res_fun), 16'd0);
    chk("reset_err", 16'(bus.res_err), 16'd0);
    rst = 1'b0;

    // Add 10+5: Arith result 15 with its flag alone high.
    drive(1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    bus.Arith_Out = 16'sd15;
    tick();
    chk("add_data", bus.res_data, 16'd15);
    chk("add_err", 16'(bus.res_err), 16'd0);

    // CMP op with a stray Logic flag -> error flagged.
    drive(1'b1, 4'b1001, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    bus.CMP_Out    = 16'sd1;
    bus.Logic_Flag = 1'b1;
    tick();
    chk("cmp_data", bus.res_data, 16'd1);
    chk("cmp_err", 16'(bus.res_err), 16'd1);
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();

    // Five back-to-back issues into a stalled FIFO: the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, funs[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("ovf_count", 16'(bus.fifo_count), 16'd4);
    chk("ovf_flag", 16'(bus.overflow), 16'd1);
    chk("ovf_drops", 16'(bus.drop_count), 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("pop_order", 16'(bus.res_fun), 16'(funs[i]));
      drive(1'b0, 4'b0000, 1'b1, 1'b0);
      tick();
    end

    // Full FIFO: push and pop in the same cycle, nothing dropped.
    async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, funs[i], 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 4'b0111, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    chk("full_pp_count", 16'(bus.fifo_count), 16'd4);
    chk("full_pp_ovf", 16'(bus.overflow), 16'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0000, 1'b1, 1'b0);
      tick();
    end
    chk("full_pp_head", 16'(bus.res_fun), 16'h7);

    // Reset with two entries queued and one op in flight.
    async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, funs[i], 1'b0, 1'b0);
      tick();
    end
    chk("pre_rst_count", 16'(bus.fifo_count), 16'd2);
    drive(1'b1, 4'b0101, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0000, 1'b1, 1'b0);
      tick();
    end
    chk("post_rst_count", 16'(bus.fifo_count), 16'd0);

    // Drop-count saturation: 4 stored, 20 dropped.
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 4'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    chk("sat_drops", 16'(bus.drop_count), 16'd15);
    chk("sat_ovf", 16'(bus.overflow), 16'd1);

    // Random traffic against the reference model.
    async_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(7) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 Parameter DEPTH, default 4; FIFO entries (power of 2, 2..16).
REQ-002 Parameter LAT, default 1; clock cycles from issue to registered ALU outputs valid (1..4).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 issue_valid  in  1  an op with issue_fun was applied to the ALU this cycle.
REQ-006 issue_fun  in  4  ALU_FUN of the issued op.
REQ-007 Arith_Out, Logic_Out, CMP_Out, Shift_Out  in  16 each, signed  registered ALU unit results.
REQ-008 Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  registered ALU unit-active flags.
REQ-009 res_valid  out  1  FIFO head holds a result.
REQ-010 res_ready  in  1  consumer accepts head.
REQ-011 res_data  out  16  head result value.
REQ-012 res_fun  out  4  head op code.
REQ-013 res_err  out  1  head flag-check failure.
REQ-014 fifo_count  out  log2(DEPTH)+1  occupied entries.
REQ-015 overflow  out  1  sticky: a result was dropped.
REQ-016 drop_count  out  4  dropped results, saturates at 15.

Function
REQ-017 Tag pipeline LAT stages deep carries {issue_valid, issue_fun}; tag exits exactly LAT cycles after issue, aligned with the ALU outputs.
REQ-018 On tag exit with valid=1, unit selected by fun[3:2]: 00 Arith, 01 Logic, 10 CMP, 11 Shift; result = selected unit's Out.
REQ-019 err=1 when the selected flag is 0 or any non-selected flag is 1; else err=0.
REQ-020 Push {result, fun, err} into FIFO in the tag-exit cycle; one push max per cycle; issue accepted every cycle (back-to-back).
REQ-021 Pop when res_valid && res_ready; res_data/res_fun/res_err show head combinationally from storage, stable while res_valid && !res_ready.
REQ-022 res_valid = (fifo_count != 0).
REQ-023 Push with FIFO full and no pop in the same cycle: entry dropped, contents unchanged, overflow set, drop_count +1 (hold at 15).
REQ-024 Push and pop same cycle: both happen, count unchanged, including when full (no drop) and when count=1 (new entry becomes head next cycle).
REQ-025 Pop with FIFO empty: ignored.
REQ-026 Read/write pointers wrap modulo DEPTH; order strictly first-in first-out.
REQ-027 overflow and drop_count clear only on reset.
REQ-028 Tag exit with valid=0: no push; ALU outputs ignored.

Reset
REQ-029 rst=1 asynchronously clears tag pipeline valids, pointers, fifo_count=0, res_valid=0, overflow=0, drop_count=0; res_data/res_fun/res_err = 0.
REQ-030 Assertion mid-operation discards all in-flight tags and FIFO contents; issues in the reset-release cycle are not captured.
REQ-031 First capturable issue is the first rising edge with rst=0.

Verification
REQ-032 LAT=1: issue 0000 with A=10,B=5, ALU Arith_Out=15 Arith_Flag=1 next cycle, res_ready=1 -> res_valid one cycle after capture, res_data=15, res_fun=0000, res_err=0.
REQ-033 Issue 1001 with CMP_Out=1, CMP_Flag=1 and Logic_Flag=1 also high -> res_data=1, res_err=1.
REQ-034 res_ready=0, 5 back-to-back issues (0000,0001,0100,1000,1100) -> fifo_count=4, overflow=1, drop_count=1; then res_ready=1 pops in order 0000,0001,0100,1000.
REQ-035 FIFO full, push and pop in same cycle -> fifo_count stays 4, overflow stays 0, new entry appears after three further pops.
REQ-036 Issue 4 ops, assert rst asynchronously between edges with 2 in FIFO and 1 in flight -> res_valid=0, fifo_count=0 immediately; no result emerges after release.
REQ-037 Drive 20 drops with res_ready=0 -> drop_count=15 saturated, overflow=1.
